freq_period_meter: RTL and testbench
====================================

Name: freq_period_meter

Overview:
- Upstream measurement stage of the frequency counter. It sits directly in front of the team's 32-bit iterative divider.
- It synchronises the asynchronous input signal and counts system-clock cycles across 2^AVG_LOG2 full input periods.
- It then issues one divide request, numerator = CLK_HZ·2^AVG_LOG2 and divisor = cycle count, and publishes the returned quotient as the measured frequency in Hz.
- A timeout path reports 0 Hz when the input is static.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- AVG_LOG2, 0, log2 of the number of input periods averaged per measurement (0..4).
- TIMEOUT_CYCLES, 50_000_000, maximum cycles spent in ARM+COUNT before a timeout is declared.
- Elaboration check: CLK_HZ<<AVG_LOG2 must be < 2^32, otherwise a fatal error.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset; one clock; synchronous, active-low.
- meas_en, input, 1, run continuous measurements while high.
- sig_in, input, 1, asynchronous signal under measurement.
- div_start, output, 1, one-cycle divide request to the divider.
- div_numerator, output, 32, dividend; stable from div_start until div_done.
- div_divisor, output, 32, divisor; stable from div_start until div_done.
- div_quotient, input, 32, divider quotient; sampled when div_done=1.
- div_done, input, 1, divider completion, level or pulse.
- freq_hz, output, 32, last published frequency.
- freq_valid, output, 1, one-cycle pulse when freq_hz updates.
- timeout, output, 1, high if the last publication was a timeout.
- busy, output, 1, high in any state except IDLE.

Behaviour:
- Reset (rst_n low at a clk edge), all outputs and internal state cleared:
  - freq_hz=0, freq_valid=0, timeout=0, div_start=0, div_numerator=0, div_divisor=0, busy=0.
  - Synchroniser flops cleared; state=IDLE.
  - Reset mid-operation abandons everything, including an outstanding divide; a stray div_done seen in IDLE is ignored.
- Input conditioning:
  - sig_in passes through a 2-flop synchroniser plus a delay flop.
  - rise = sync & ~delayed, a one-cycle pulse.
  - Latency from a sig_in edge to rise is 3 clk cycles.
  - Consecutive rise pulses are at least 2 cycles apart by construction.
- IDLE: busy=0. meas_en=1 -> ARM.
- ARM:
  - tmr increments each cycle.
  - On rise: cyc<=0, edges<=0, go to COUNT; tmr keeps running.
- COUNT:
  - cyc<=cyc+1 every cycle.
  - On rise with edges==2^AVG_LOG2-1: latch divisor=cyc+1 and numerator=CLK_HZ<<AVG_LOG2, go to ISSUE.
  - On any other rise: edges+1.
  - Result: a square wave of period P cycles gives divisor = 2^AVG_LOG2·P exactly.
- Timeout:
  - Applies in ARM or COUNT when tmr reaches TIMEOUT_CYCLES-1.
  - Next cycle: freq_hz<=0, timeout<=1, freq_valid pulses, tmr<=0, go to ARM (or IDLE if meas_en=0).
  - No divide is issued.
- ISSUE: div_start=1 for exactly one cycle, then WAIT_DONE. div_numerator and div_divisor are already valid in that cycle.
- WAIT_DONE:
  - On the first cycle with div_done=1: freq_hz<=div_quotient, timeout<=0, freq_valid pulses the following cycle, tmr<=0.
  - Then go to ARM if meas_en=1, else IDLE.
  - div_done is honoured only in WAIT_DONE.
  - Outputs hold; no new request until the handshake completes.
- Re-arm: ARM waits for a fresh rise, so consecutive measurements are disjoint. Edges occurring during the divide are not counted.
- meas_en deasserted:
  - In ARM or COUNT: go to IDLE next cycle; no publication.
  - In ISSUE or WAIT_DONE: the handshake completes and the result is published, then IDLE.
- Arithmetic:
  - cyc and tmr are 32 bits. The timeout bounds them, so no wrap occurs.
  - The divisor is never 0.
- Simultaneous events:
  - rise and timeout in the same cycle: timeout wins.
  - Final rise and meas_en falling together: go to IDLE, no divide.

Test Plan:
- CLK_HZ=50e6, AVG_LOG2=0, sig period 5000 clk -> div_divisor=5000, div_numerator=50_000_000; divider returns 10000 -> freq_hz=10000, freq_valid one pulse, timeout=0.
- AVG_LOG2=2, period 7 clk -> div_divisor=28, div_numerator=200_000_000, freq_hz=7_142_857; back-to-back results are spaced by at least 4 periods plus divider latency.
- sig_in held low, TIMEOUT_CYCLES=1000 -> freq_valid after 1001 cycles with freq_hz=0, timeout=1; then a 100-clk-period input -> freq_hz=500_000, timeout=0.
- Divider model with 40-cycle latency, sig_in toggling during the wait -> div_numerator/div_divisor stable, no second div_start until after div_done; the next count starts at a fresh edge.
- meas_en dropped mid-COUNT -> IDLE next cycle, no div_start, busy=0; meas_en dropped in WAIT_DONE -> result published, then IDLE.
- rst_n low for one cycle during WAIT_DONE -> all outputs 0 next cycle; a later div_done is ignored; a new measurement succeeds.

Source files
------------

// File: rtl/freq_period_meter.sv
// Frequency meter front end: times 2^AVG_LOG2 input periods in clk cycles,
// hands CLK_HZ*2^AVG_LOG2 / cycles to the shared iterative divider and
// publishes the quotient in Hz. A static input is reported as 0 Hz after
// TIMEOUT_CYCLES.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | measurement disabled, divide port quiet
//   ARM    | waiting for a fresh rising edge to open the window
//   COUNT  | counting clk cycles until 2^AVG_LOG2 more rising edges
//   ISSUE  | one-cycle divide request, operands already latched
//   WAIT   | holding operands until the divider reports done
module freq_period_meter #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned AVG_LOG2       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        meas_en,
  input  logic        sig_in,
  output logic        div_start,
  output logic [31:0] div_numerator,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic        div_done,
  output logic [31:0] freq_hz,
  output logic        freq_valid,
  output logic        timeout,
  output logic        busy
);

  localparam logic [63:0] NUM_WIDE  = 64'(CLK_HZ) << AVG_LOG2;
  localparam logic [31:0] NUM_VAL   = NUM_WIDE[31:0];
  localparam logic [4:0]  LAST_EDGE = 5'((1 << AVG_LOG2) - 1);
  localparam logic [31:0] TMR_LAST  = 32'(TIMEOUT_CYCLES - 1);

  // The numerator must fit the 32-bit divider and the edge counter is 5 bits.
  if (NUM_WIDE >= 64'h1_0000_0000) begin : g_num_too_wide
    $fatal(1, "freq_period_meter: CLK_HZ << AVG_LOG2 does not fit in 32 bits");
  end
  if (AVG_LOG2 > 4) begin : g_avg_too_large
    $fatal(1, "freq_period_meter: AVG_LOG2 must be 0..4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, dly_q;
  logic        rise;
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] cyc_q, cyc_d;
  logic [4:0]  edges_q, edges_d;
  logic [31:0] num_q, num_d;
  logic [31:0] den_q, den_d;
  logic [31:0] freq_q, freq_d;
  logic        valid_q, valid_d;
  logic        tout_q, tout_d;
  logic        tmr_expired;

  assign rise        = sync2_q & ~dly_q;
  assign tmr_expired = (tmr_q == TMR_LAST);

  // Input synchroniser plus delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      cyc_q   <= '0;
      edges_q <= '0;
      num_q   <= '0;
      den_q   <= '0;
      freq_q  <= '0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cyc_q   <= cyc_d;
      edges_q <= edges_d;
      num_q   <= num_d;
      den_q   <= den_d;
      freq_q  <= freq_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
    end
  end

  // Next-state logic; timeout beats meas_en dropping, which beats a rise.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cyc_d   = cyc_q;
    edges_d = edges_q;
    num_d   = num_q;
    den_d   = den_q;
    freq_d  = freq_q;
    valid_d = 1'b0;
    tout_d  = tout_q;

    case (state_q)
      S_IDLE: begin
        if (meas_en) begin
          state_d = S_ARM;
          tmr_d   = '0;
        end
      end

      S_ARM, S_COUNT: begin
        tmr_d = tmr_q + 32'd1;
        if (state_q == S_COUNT) begin
          cyc_d = cyc_q + 32'd1;
        end
        if (tmr_expired) begin
          freq_d  = '0;
          tout_d  = 1'b1;
          valid_d = 1'b1;
          tmr_d   = '0;
          state_d = meas_en ? S_ARM : S_IDLE;
        end else if (!meas_en) begin
          state_d = S_IDLE;
        end else if (rise) begin
          if (state_q == S_ARM) begin
            cyc_d   = '0;
            edges_d = '0;
            state_d = S_COUNT;
          end else if (edges_q == LAST_EDGE) begin
            // The closing edge itself ends the last period, hence +1.
            den_d   = cyc_q + 32'd1;
            num_d   = NUM_VAL;
            state_d = S_ISSUE;
          end else begin
            edges_d = edges_q + 5'd1;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (div_done) begin
          freq_d  = div_quotient;
          tout_d  = 1'b0;
          valid_d = 1'b1;
          tmr_d   = '0;
          state_d = meas_en ? S_ARM : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign div_start     = (state_q == S_ISSUE);
  assign div_numerator = num_q;
  assign div_divisor   = den_q;
  assign freq_hz       = freq_q;
  assign freq_valid    = valid_q;
  assign timeout       = tout_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_freq_period_meter.sv
// Scoreboarded bench for freq_period_meter with a behavioural divider and a
// square-wave source whose expected frequency is simply CLK_HZ / period.
module tb_freq_period_meter;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned AVG     = 2;
  localparam int unsigned TO      = 2000;
  localparam longint      NUM_EXP = longint'(CLK_HZ) * longint'(1 << AVG);

  typedef struct {
    bit     is_to;
    longint den;
    longint freq;
    longint min_gap;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        meas_en;
  logic        sig_in;
  logic        div_start;
  logic [31:0] div_numerator;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic        div_done;
  logic [31:0] freq_hz;
  logic        freq_valid;
  logic        timeout;
  logic        busy;

  int     total = 0;
  int     bad = 0;
  exp_t   exp_q[$];
  longint cyc_cnt = 0;
  longint last_valid_cyc = 0;
  int     start_cnt = 0;
  int     valid_cnt = 0;
  int     flush_cnt = 0;
  bit     outstanding = 0;
  int     per = 0;
  int     lat = 1;

  freq_period_meter #(
    .CLK_HZ(CLK_HZ),
    .AVG_LOG2(AVG),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .meas_en(meas_en),
    .sig_in(sig_in),
    .div_start(div_start),
    .div_numerator(div_numerator),
    .div_divisor(div_divisor),
    .div_quotient(div_quotient),
    .div_done(div_done),
    .freq_hz(freq_hz),
    .freq_valid(freq_valid),
    .timeout(timeout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Square wave of 'per' clk cycles (0 = held low), restarted high on change.
  initial begin
    int ph;
    int per_last;
    ph = 0;
    per_last = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (per != per_last) begin
        per_last = per;
        ph = 0;
      end else if (per != 0) begin
        ph = (ph + 1) % per;
      end
      sig_in = (per != 0) && (ph < per - per / 2);
    end
  end

  // Divider model: fixed-latency pulse of div_done carrying num/den.
  initial begin
    longint n;
    longint d;
    div_done = 1'b0;
    div_quotient = '0;
    forever begin
      @(negedge clk);
      if (div_start) begin
        n = longint'(div_numerator);
        d = longint'(div_divisor);
        repeat (lat) @(negedge clk);
        div_quotient = (d != 0) ? 32'(n / d) : 32'hFFFF_FFFF;
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
      end
    end
  end

  // Monitor: compares every divide request and publication with the queue.
  initial begin
    int     flush_seen;
    bit     prev_valid;
    longint cap_num;
    longint cap_den;
    exp_t   e;
    flush_seen = 0;
    prev_valid = 0;
    cap_num = 0;
    cap_den = 0;
    forever begin
      @(posedge clk);
      #1;
      if (flush_cnt != flush_seen) begin
        flush_seen = flush_cnt;
        exp_q.delete();
        outstanding = 0;
      end
      if (div_start) begin
        start_cnt++;
        check("start_while_outstanding", longint'(outstanding), 0);
        if (exp_q.size() == 0 || exp_q[0].is_to) begin
          check("unexpected_start", 1, 0);
        end else begin
          check("divisor", longint'(div_divisor), exp_q[0].den);
          check("numerator", longint'(div_numerator), NUM_EXP);
        end
        outstanding = 1;
        cap_num = longint'(div_numerator);
        cap_den = longint'(div_divisor);
      end else if (outstanding && div_done) begin
        check("numerator_stable", longint'(div_numerator), cap_num);
        check("divisor_stable", longint'(div_divisor), cap_den);
        outstanding = 0;
      end
      if (freq_valid) begin
        valid_cnt++;
        check("valid_single_pulse", longint'(prev_valid), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("freq_hz", longint'(freq_hz), e.freq);
          check("timeout_flag", longint'(timeout), longint'(e.is_to));
          if (e.min_gap > 0)
            check("result_spacing_ok", longint'((cyc_cnt - last_valid_cyc) >= e.min_gap), 1);
        end
        last_valid_cyc = cyc_cnt;
      end
      prev_valid = freq_valid;
    end
  end

  task automatic push_meas(input int p, input longint gap);
    exp_t e;
    e.is_to   = 0;
    e.den     = longint'(p) * longint'(1 << AVG);
    e.freq    = longint'(CLK_HZ) / longint'(p);
    e.min_gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !outstanding) done = 1;
    end
    if (!done) check("scoreboard_drain_in_budget", 0, 1);
  endtask

  task automatic wait_start(input int budget);
    int s0;
    bit done;
    s0 = start_cnt;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (start_cnt != s0) done = 1;
    end
    if (!done) check("div_start_in_budget", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_freq_hz"}, longint'(freq_hz), 0);
    check({tag, "_freq_valid"}, longint'(freq_valid), 0);
    check({tag, "_timeout"}, longint'(timeout), 0);
    check({tag, "_div_start"}, longint'(div_start), 0);
    check({tag, "_div_numerator"}, longint'(div_numerator), 0);
    check({tag, "_div_divisor"}, longint'(div_divisor), 0);
    check({tag, "_busy"}, longint'(busy), 0);
  endtask

  task automatic stop_and_check_idle(input string tag);
    meas_en = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_busy_after_stop"}, longint'(busy), 0);
  endtask

  initial begin
    int     p;
    longint c;
    int     v0;
    int     s0;
    exp_t   e;

    rst_n = 1'b0;
    meas_en = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Period 7, averaged over 4 periods: 200e6 / 28.
    per = 7;
    lat = 10;
    push_meas(7, 0);
    meas_en = 1'b1;
    wait_empty(3000);
    check("p7_freq_value", longint'(freq_hz), 7_142_857);
    stop_and_check_idle("p7");

    // Randomised periods and divider latencies, two back-to-back results each.
    for (int k = 0; k < 6; k++) begin
      p = int'($urandom_range(4, 360));
      per = p;
      lat = int'($urandom_range(1, 40));
      push_meas(p, 0);
      push_meas(p, longint'(p) * longint'(1 << AVG) + longint'(lat));
      meas_en = 1'b1;
      wait_empty(6000);
      stop_and_check_idle("rand");
    end

    // Static input: timeout publication, then recovery with a 100-cycle period.
    per = 0;
    repeat (5) @(negedge clk);
    e.is_to = 1;
    e.den = 0;
    e.freq = 0;
    e.min_gap = 0;
    exp_q.push_back(e);
    c = cyc_cnt;
    meas_en = 1'b1;
    wait_empty(TO + 100);
    check("timeout_latency", last_valid_cyc - c, longint'(TO) + 1);
    per = 100;
    lat = 8;
    push_meas(100, 0);
    wait_empty(3000);
    check("recovery_freq_value", longint'(freq_hz), 500_000);
    stop_and_check_idle("recovery");

    // meas_en dropped mid-count: idle next cycle, nothing issued or published.
    per = 300;
    meas_en = 1'b1;
    repeat (700) @(negedge clk);
    s0 = start_cnt;
    v0 = valid_cnt;
    meas_en = 1'b0;
    @(negedge clk);
    check("drop_count_busy", longint'(busy), 0);
    repeat (50) @(negedge clk);
    check("drop_count_no_start", start_cnt, s0);
    check("drop_count_no_valid", valid_cnt, v0);

    // meas_en dropped while the divide is outstanding: result still published.
    per = 50;
    lat = 40;
    push_meas(50, 0);
    meas_en = 1'b1;
    wait_start(3000);
    meas_en = 1'b0;
    wait_empty(200);
    @(negedge clk);
    check("drop_wait_busy", longint'(busy), 0);
    check("drop_wait_freq", longint'(freq_hz), 1_000_000);

    // One-cycle reset while waiting on the divider; the late done is ignored.
    per = 60;
    lat = 40;
    push_meas(60, 0);
    meas_en = 1'b1;
    wait_start(3000);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    meas_en = 1'b0;
    flush_cnt++;
    @(negedge clk);
    check_all_zero("midreset");
    rst_n = 1'b1;
    v0 = valid_cnt;
    repeat (60) @(negedge clk);
    check("stray_done_no_valid", valid_cnt, v0);
    check("stray_done_busy", longint'(busy), 0);
    p = int'($urandom_range(4, 360));
    per = p;
    lat = 5;
    push_meas(p, 0);
    meas_en = 1'b1;
    wait_empty(3000);
    stop_and_check_idle("post_reset");

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
